// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WDTH data bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit between the data and stop bits.
module uart_tx #(
  parameter int FREQ_CLK  = 100000000,
  parameter int DATA_WDTH = 8,
  parameter int DEF_BAUD  = 115200
) (
  input  logic                 CLKip,
  input  logic                 rst,
  input  logic [31:0]          BAUD_RATEi,
  input  logic                 BAUD_RATE_WEi,
  input  logic                 VALIDi,
  input  logic [DATA_WDTH-1:0] DATAi,
  output logic                 READYo,
  output logic                 TXo,
  output logic                 DONEo
);

  localparam int IDX_W = $clog2(DATA_WDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WDTH - 1);
  localparam logic [31:0] FREQ_U = 32'(FREQ_CLK);
  localparam logic [31:0] DEF_Q  = 32'(FREQ_CLK / DEF_BAUD);
  localparam logic [31:0] DEF_N  = (DEF_Q < 32'd2) ? 32'd2 : DEF_Q;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state, state_next;
  logic [31:0]            bit_period;
  logic [31:0]            frame_n, frame_n_next;
  logic [31:0]            cnt, cnt_next;
  logic [IDX_W-1:0]       idx, idx_next;
  logic [DATA_WDTH-1:0]   shift, shift_next;
  logic [31:0]            quot;
  logic                   accept;
  logic                   bit_end;
  logic                   tx_next, ready_next, done_next;

  assign quot   = FREQ_U / BAUD_RATEi;
  assign accept = READYo && VALIDi;

  // Requested bit period; frames pick it up only when they are accepted.
  always_ff @(posedge CLKip) begin
    if (rst)
      bit_period <= DEF_N;
    else if (BAUD_RATE_WEi && (BAUD_RATEi != 32'd0))
      bit_period <= (quot < 32'd2) ? 32'd2 : quot;
  end

`ifdef UART_TX_PARITY_EN
  logic parity;

  always_ff @(posedge CLKip) begin
    if (rst)
      parity <= 1'b0;
    else if (accept)
      parity <= ^DATAi;
  end
`endif

  always_ff @(posedge CLKip) begin
    if (rst) begin
      state   <= IDLE;
      frame_n <= DEF_N;
      cnt     <= 32'd0;
      idx     <= '0;
      shift   <= '0;
      TXo     <= 1'b1;
      READYo  <= 1'b0;
      DONEo   <= 1'b0;
    end else begin
      state   <= state_next;
      frame_n <= frame_n_next;
      cnt     <= cnt_next;
      idx     <= idx_next;
      shift   <= shift_next;
      TXo     <= tx_next;
      READYo  <= ready_next;
      DONEo   <= done_next;
    end
  end

  // Outputs are computed for the state being entered so they come straight off flops.
  always_comb begin
    state_next   = state;
    frame_n_next = frame_n;
    cnt_next     = cnt;
    idx_next     = idx;
    shift_next   = shift;
    tx_next      = 1'b1;
    ready_next   = 1'b0;
    done_next    = 1'b0;
    bit_end      = (cnt == frame_n - 32'd1);

    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next   = START;
          frame_n_next = bit_period;
          cnt_next     = 32'd0;
          idx_next     = '0;
          shift_next   = DATAi;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          cnt_next   = 32'd0;
          idx_next   = '0;
        end else begin
          cnt_next = cnt + 32'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_next = 32'd0;
          if (idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            idx_next   = idx + IDX_W'(1);
            shift_next = shift >> 1;
          end
        end else begin
          cnt_next = cnt + 32'd1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
          cnt_next   = 32'd0;
        end else begin
          cnt_next = cnt + 32'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          cnt_next   = 32'd0;
        end else begin
          cnt_next = cnt + 32'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    case (state_next)
      IDLE:    ready_next = 1'b1;
      START:   tx_next    = 1'b0;
      DATA:    tx_next    = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next    = parity;
`endif
      default: tx_next    = 1'b1;
    endcase

    done_next = (state_next == STOP) && (cnt_next == frame_n_next - 32'd1);
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a waveform-level model checked every cycle, plus literal frame checks.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx;

  localparam longint FREQ  = 100000000;
  localparam int     DEF_N = 868;
`ifdef UART_TX_PARITY_EN
  localparam int BITS = 11;
  int pat_a5[BITS] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
  int pat_3c[BITS] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1};
`else
  localparam int BITS = 10;
  int pat_a5[BITS] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  int pat_3c[BITS] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1};
`endif
  localparam int LIMIT = 20000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] baud = 32'd0;
  logic        baud_we = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        ready, tx, done;

  int compared = 0;
  int failed = 0;
  int cyc = 0;

  uart_tx dut (
    .CLKip(clk), .rst(rst), .BAUD_RATEi(baud), .BAUD_RATE_WEi(baud_we),
    .VALIDi(valid), .DATAi(data), .READYo(ready), .TXo(tx), .DONEo(done)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: each accepted frame expands into a per-cycle queue of {tx, done}.
  logic [1:0] wave[$];
  longint     m_n = DEF_N;
  logic       exp_tx = 1'b1, exp_ready = 1'b0, exp_done = 1'b0;
  bit         model_on = 0;

  function automatic longint periodFor(input longint b);
    longint q = FREQ / b;
    return (q < 2) ? 2 : q;
  endfunction

  task automatic buildFrame(input logic [7:0] d, input longint n);
    int bits[$];
    bits.push_back(0);
    for (int i = 0; i < 8; i++) bits.push_back(int'(d[i]));
`ifdef UART_TX_PARITY_EN
    bits.push_back(int'(^d));
`endif
    bits.push_back(1);
    foreach (bits[b])
      for (longint k = 0; k < n; k++) wave.push_back({bits[b][0], 1'b0});
    void'(wave.pop_back());
    wave.push_back(2'b11);
  endtask

  always @(posedge clk) begin
    logic [1:0] e;
    if (rst) begin
      wave.delete();
      m_n = DEF_N;
      exp_tx = 1'b1; exp_ready = 1'b0; exp_done = 1'b0;
    end else begin
      if (exp_ready && valid) buildFrame(data, m_n);
      if (baud_we && baud != 0) m_n = periodFor(longint'(baud));
      if (wave.size() > 0) begin
        e = wave.pop_front();
        exp_tx = e[1]; exp_done = e[0]; exp_ready = 1'b0;
      end else begin
        exp_tx = 1'b1; exp_done = 1'b0; exp_ready = 1'b1;
      end
    end
    model_on = 1;
  end

  always @(negedge clk) begin
    if (model_on) begin
      checkOutput("tx", tx, exp_tx);
      checkOutput("ready", ready, exp_ready);
      checkOutput("done", done, exp_done);
    end
  end

  task automatic writeBaud(input logic [31:0] b);
    baud = b; baud_we = 1'b1;
    @(negedge clk);
    baud_we = 1'b0;
  endtask

  // Returns at the negedge of frame cycle 1 (first start-bit cycle).
  task automatic sendFrame(input logic [7:0] d, input bit hold, output int start);
    int k = 0;
    valid = 1'b1; data = d;
    while (!ready && k < LIMIT) begin @(negedge clk); k++; end
    if (k >= LIMIT) checkOutput("ready_timeout", 0, 1);
    @(negedge clk);
    if (!hold) begin valid = 1'b0; data = ~d; end
    start = cyc;
  endtask

  task automatic waitDone(output int at);
    for (int i = 0; i < LIMIT; i++) begin
      if (done) begin at = cyc; return; end
      @(negedge clk);
    end
    checkOutput("done_timeout", 0, 1);
    at = cyc;
  endtask

  // Walks a frame from cycle 1, checking mid-bit levels and the DONE position against literals.
  task automatic walkFrame(input int pat[BITS], input int n, input string name);
    for (int fc = 1; fc <= n * BITS; fc++) begin
      if ((fc - 1) % n == n / 2) checkOutput({name, "_bit"}, tx, pat[(fc - 1) / n]);
      if (fc == n * BITS - 1) checkOutput({name, "_done_early"}, done, 0);
      if (fc == n * BITS) checkOutput({name, "_done_last"}, done, 1);
      @(negedge clk);
    end
    checkOutput({name, "_ready_after"}, ready, 1);
  endtask

  task automatic applyStimulus(input int cycles);
    bit prev_rst = 0;
    for (int i = 0; i < cycles; i++) begin
      if (prev_rst) begin
        rst = 1'b0; valid = 1'b0; prev_rst = 0;
        baud_we = 1'b1; baud = $urandom_range(5000000, 60000000);
      end else begin
        rst = ($urandom_range(0, 599) == 0);
        prev_rst = rst;
        valid = ($urandom_range(0, 3) == 0);
        data = 8'($urandom);
        baud_we = ($urandom_range(0, 79) == 0);
        case ($urandom_range(0, 3))
          0: baud = 32'd0;
          1: baud = 32'd200000000;
          default: baud = $urandom_range(5000000, 60000000);
        endcase
      end
      @(negedge clk);
    end
    rst = 1'b0; valid = 1'b0; baud_we = 1'b0;
  endtask

  initial begin
    int s, d1, d2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_tx", tx, 1);
      checkOutput("rst_ready", ready, 0);
      checkOutput("rst_done", done, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    checkOutput("release_ready", ready, 1);

    writeBaud(32'd10000000);
    sendFrame(8'hA5, 0, s);
    walkFrame(pat_a5, 10, "a5");

    // Back-to-back with VALID held; data changes while busy must be ignored until the next accept.
    sendFrame(8'h00, 1, s);
    data = 8'hFF;
    waitDone(d1);
    checkOutput("b2b_first_len", d1 - s + 1, 10 * BITS);
    @(negedge clk);
    checkOutput("b2b_gap_tx", tx, 1);
    checkOutput("b2b_gap_ready", ready, 1);
    @(negedge clk);
    checkOutput("b2b_second_start", tx, 0);
    s = cyc;
    valid = 1'b0; data = 8'h12;
    waitDone(d2);
    checkOutput("b2b_second_len", d2 - s + 1, 10 * BITS);
    checkOutput("b2b_start_offset", s - d1, 2);
    @(negedge clk);

    // Baud change mid-frame only affects the following frame.
    sendFrame(8'h5A, 0, s);
    repeat (29) @(negedge clk);
    writeBaud(32'd5000000);
    waitDone(d1);
    checkOutput("midwrite_cur_len", d1 - s + 1, 10 * BITS);
    @(negedge clk);
    sendFrame(8'h81, 0, s);
    waitDone(d1);
    checkOutput("midwrite_next_len", d1 - s + 1, 20 * BITS);
    @(negedge clk);

    writeBaud(32'd0);
    sendFrame(8'h42, 0, s);
    waitDone(d1);
    checkOutput("baud0_len", d1 - s + 1, 20 * BITS);
    @(negedge clk);
    writeBaud(32'd200000000);
    sendFrame(8'hC3, 0, s);
    waitDone(d1);
    checkOutput("clamp_len", d1 - s + 1, 2 * BITS);
    @(negedge clk);

    // Write and acceptance on the same edge: this frame keeps the old period.
    valid = 1'b1; data = 8'h99; baud = 32'd10000000; baud_we = 1'b1;
    @(negedge clk);
    valid = 1'b0; baud_we = 1'b0;
    s = cyc;
    waitDone(d1);
    checkOutput("same_edge_len", d1 - s + 1, 2 * BITS);
    @(negedge clk);
    sendFrame(8'h99, 0, s);
    waitDone(d1);
    checkOutput("after_same_edge_len", d1 - s + 1, 10 * BITS);
    @(negedge clk);

    // Reset in the middle of data bit 3, then a clean frame at the reset-default period.
    sendFrame(8'h3C, 0, s);
    repeat (44) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_tx", tx, 1);
    checkOutput("abort_ready", ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_release_ready", ready, 1);
    sendFrame(8'h3C, 0, s);
    walkFrame(pat_3c, DEF_N, "3c");

    writeBaud(32'd10000000);
    applyStimulus(4000);
    repeat (300) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
